si_tag_decoder: RTL and testbench
=================================

# si_tag_decoder

Parametrised successor to the multi-tag converter. Each cycle it parses up to `NUMBER_OF_WORDS` 32-bit Time Tagger tag words from a wide AXI-Stream beat into absolute 64-bit timestamps and signed channel numbers. It adds three features:
- a per-channel programmable delay offset;
- a per-channel enable mask;
- a saturating dropped-tag counter.

Rollover detection is epoch-correct. It sits between the link de-framer and the user measurement blocks; the downstream `m_axis` interface honours backpressure.

## Interface
- `CHANNEL_COUNT`, 20: internal channel count; valid channel numbers are 0 .. 2*CHANNEL_COUNT-1.
- `DATA_WIDTH_IN`, 128: input data width (multiple of 32).
- `KEEP_WIDTH_IN`, (DATA_WIDTH_IN+7)/8: input tkeep width.
- `NUMBER_OF_WORDS`, (DATA_WIDTH_IN+31)/32: tag lanes.
- `TIME_SCALE`, 4000: time units (1/3 ps) per counter tick.
- `CH_ADDR_W`, $clog2(CHANNEL_COUNT): config address width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: equals `m_axis_tready || !m_axis_tvalid`.
- `s_axis_tdata` in DATA_WIDTH_IN: tag words; lane i is bits [32i+31:32i].
- `s_axis_tlast` in 1: ignored.
- `s_axis_tkeep` in KEEP_WIDTH_IN: lane i is present only when keep[4i+3:4i] == 4'hF.
- `s_axis_tuser` in 32: wrap count of the beat.
- `m_axis_tvalid` out 1: OR of `m_axis_tkeep`.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tagtime` out 64 x NUMBER_OF_WORDS: absolute time in 1/3 ps.
- `m_axis_channel` out signed 6 x NUMBER_OF_WORDS: +1..+CC for rising edges, -1..-CC for falling edges.
- `m_axis_tkeep` out NUMBER_OF_WORDS: lane carries a valid, enabled tag.
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in CH_ADDR_W: channel index 0..CC-1; the entry applies to both edges.
- `cfg_offset` in signed 32: delay offset in 1/3 ps.
- `cfg_enable` in 1: channel enable.
- `dropped_count` out 32: count of disabled-channel tags; saturating.
- `rollover_count` out 32: current rollover epoch.

## Operation
- Lane word fields:
  - [31:30] event type; only 2'b01 is a tag.
  - [29:24] channel number n.
  - [23:12] subtime.
  - [11:0] counter.
- A lane is a tag when it is present, type == 01, and n < 2*CHANNEL_COUNT. Any other word gives keep 0 on that lane and is not counted.
- Channel index: c = n for n < CC, else n - CC.
- Signed channel output: n+1 for n < CC, else CC-1-n.
- Base time: ({rollover, tuser, counter} as 76-bit unsigned × TIME_SCALE), truncated to 64 bits.
- Output time: base + subtime + sign-extended offset[c], modulo 2^64. A negative result wraps; no clamping.
- Enable mask:
  - A tag on a disabled channel gives lane keep 0.
  - The dropped counter is incremented by the number of such lanes in that beat, saturating at 32'hFFFF_FFFF.
- Rollover: on each accepted beat (valid & ready & any keep bit set):
  - if a previous tuser exists and tuser < prev_tuser, rollover increments;
  - the decrementing beat already uses the incremented epoch;
  - the first accepted beat after reset never increments.
- Config write: when `cfg_we` is high and `cfg_addr` < CC, offset and enable are written at the clock edge. An out-of-range address is ignored.
  - The new values apply to beats accepted on the following cycle or later.
  - A beat accepted on the write cycle uses the old values.

## Timing
- Fixed 4-stage pipeline. All stages advance only when `s_axis_tready` is high.
- With ready held high, a beat accepted at cycle t appears on `m_axis` at cycle t+4.
- Stall (`m_axis_tvalid` & !`m_axis_tready`): all outputs hold stable, no input is accepted, and no counters change.
- Empty pipeline bubbles propagate with keep 0. Bubbles never block input because tready is high while `m_axis_tvalid` is 0.
- Multiplication is stage 1 and offset/subtime addition is stages 2-3. Both are registered and pipelined in DSP-friendly steps.
- Reset values:
  - all pipeline registers 0;
  - `m_axis_tvalid`, `m_axis_tkeep`, `m_axis_tagtime`, `m_axis_channel` all 0;
  - `rollover_count`, `dropped_count` 0, and the previous-tuser-valid flag cleared;
  - all offsets 0 and all enables 1.
- Reset asserted mid-stream discards in-flight beats; the next cycle outputs are the reset values.
- `dropped_count` updates 1 cycle after beat acceptance. Simultaneous drops in several lanes add their sum in one cycle.

## Test plan
- Single lane word 0x41_001_005 (n=1), tuser=0, ready high → at t+4: keep=0001, channel=+2, tagtime=5*4000+1=20001.
- Word with n=20 (CC=20) in lane 3 and n=39 in lane 0 → channels -1 and -20, keep=1001; n=40 and type 00 words give keep 0.
- Write offset[2]=-30000 then send n=2 with counter=1, subtime=0 → tagtime=4000-30000 wrapped = 2^64-26000. Write offset and send a beat on the same cycle → old offset is used.
- Disable channel 5, send 3 lanes with n=5 and n=25 → keep 0 on those lanes, `dropped_count`=3. Force the count to 32'hFFFF_FFFE plus 3 drops → 32'hFFFF_FFFF.
- tuser sequence 0xFFFFFFFF, 0x00000000 → `rollover_count` goes 0→1; the second beat's tagtime equals (2^44)*4000 + counter*4000 + subtime. The first beat after reset, with tuser 0, gives no increment.
- Hold `m_axis_tready` low for 10 cycles with valid output → outputs constant, `s_axis_tready`=0, no beat lost. Assert rst while stalled → outputs 0 next cycle.

Source files
------------

// File: rtl/si_tag_decoder.sv
// si_tag_decoder
// Parses up to NUMBER_OF_WORDS Time Tagger tag words per AXI-Stream beat into
// absolute 64-bit timestamps (1/3 ps units) and signed channel numbers.
// Adds a per-channel delay offset, a per-channel enable mask, a saturating
// dropped-tag counter and epoch-correct rollover tracking.
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   s_axis_*            : input beats (tdata lanes of 32 bits, tkeep per byte,
//                         tuser = wrap count of the beat, tlast ignored)
//   m_axis_*            : per-lane tagtime / channel / keep, tvalid = |tkeep
//   cfg_we/addr/offset/enable : per-channel configuration write port
//   dropped_count       : saturating count of tags on disabled channels
//   rollover_count      : current rollover epoch
module si_tag_decoder #(
   parameter int CHANNEL_COUNT   = 20,
   parameter int DATA_WIDTH_IN   = 128,
   parameter int KEEP_WIDTH_IN   = (DATA_WIDTH_IN + 7) / 8,
   parameter int NUMBER_OF_WORDS = (DATA_WIDTH_IN + 31) / 32,
   parameter int TIME_SCALE      = 4000,
   parameter int CH_ADDR_W       = $clog2(CHANNEL_COUNT)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                s_axis_tvalid,
   output logic                                s_axis_tready,
   input  logic [DATA_WIDTH_IN-1:0]            s_axis_tdata,
   input  logic                                s_axis_tlast,
   input  logic [KEEP_WIDTH_IN-1:0]            s_axis_tkeep,
   input  logic [31:0]                         s_axis_tuser,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic [NUMBER_OF_WORDS-1:0][63:0]    m_axis_tagtime,
   output logic [NUMBER_OF_WORDS-1:0][5:0]     m_axis_channel,  // two's complement per lane
   output logic [NUMBER_OF_WORDS-1:0]          m_axis_tkeep,
   input  logic                                cfg_we,
   input  logic [CH_ADDR_W-1:0]                cfg_addr,
   input  logic signed [31:0]                  cfg_offset,
   input  logic                                cfg_enable,
   output logic [31:0]                         dropped_count,
   output logic [31:0]                         rollover_count
);

   localparam int          NW        = NUMBER_OF_WORDS;
   localparam logic [5:0]  CC_N      = 6'(CHANNEL_COUNT);
   localparam logic [5:0]  TAG_LIMIT = 6'(2 * CHANNEL_COUNT);
   localparam logic [63:0] SCALE     = 64'(TIME_SCALE);

   // configuration and counters
   logic [31:0]              offset_r [CHANNEL_COUNT];
   logic [CHANNEL_COUNT-1:0] enable_r;
   logic [31:0]              rollover_r;
   logic [31:0]              prev_tuser_r;
   logic                     prev_valid_r;
   logic [31:0]              drop_cnt_r;

   // stage 0 (combinational decode of the incoming beat)
   logic                     advance_s;
   logic                     accept_s;
   logic [31:0]              rollover_next_s;
   logic [31:0]              drop_inc_s;
   logic [32:0]              drop_sum_s;
   logic [NW-1:0]            lane_keep_s;
   logic [NW-1:0]            lane_drop_s;
   logic [NW-1:0][5:0]       lane_chan_s;
   logic [NW-1:0][63:0]      lane_prod_s;
   logic [NW-1:0][11:0]      lane_sub_s;
   logic [NW-1:0][31:0]      lane_off_s;
   logic                     unused_s;

   // pipeline registers
   logic [NW-1:0]            s1_keep_r;
   logic [NW-1:0][5:0]       s1_chan_r;
   logic [NW-1:0][63:0]      s1_prod_r;
   logic [NW-1:0][11:0]      s1_sub_r;
   logic [NW-1:0][31:0]      s1_off_r;
   logic [NW-1:0]            s2_keep_r;
   logic [NW-1:0][5:0]       s2_chan_r;
   logic [NW-1:0][63:0]      s2_sum_r;
   logic [NW-1:0][31:0]      s2_off_r;
   logic [NW-1:0]            s3_keep_r;
   logic [NW-1:0][5:0]       s3_chan_r;
   logic [NW-1:0][63:0]      s3_time_r;

   assign unused_s       = s_axis_tlast;
   // The whole pipeline moves in lock-step; bubbles at the output never block.
   assign s_axis_tready  = m_axis_tready || !m_axis_tvalid;
   assign advance_s      = s_axis_tready;
   assign accept_s       = s_axis_tvalid && s_axis_tready && (|s_axis_tkeep);
   assign dropped_count  = drop_cnt_r;
   assign rollover_count = rollover_r;

   // Epoch for the incoming beat: a decreasing wrap count bumps the epoch and
   // the decreasing beat itself already uses the new epoch.
   always_comb begin
      rollover_next_s = rollover_r;
      if (prev_valid_r && (s_axis_tuser < prev_tuser_r)) begin
         rollover_next_s = rollover_r + 32'd1;
      end else begin
         rollover_next_s = rollover_r;
      end
   end

   // Per-lane decode: tag qualification, channel mapping, config lookup and
   // the base-time multiply (registered in stage 1).
   always_comb begin
      lane_keep_s = '0;
      lane_drop_s = '0;
      lane_chan_s = '0;
      lane_prod_s = '0;
      lane_sub_s  = '0;
      lane_off_s  = '0;
      drop_inc_s  = 32'd0;
      for (int i = 0; i < NW; i++) begin : g_lane
         logic [31:0]          word;
         logic [5:0]           n;
         logic                 is_tag;
         logic                 en;
         logic [CH_ADDR_W-1:0] idx;
         word   = s_axis_tdata[32*i +: 32];
         n      = word[29:24];
         is_tag = (&s_axis_tkeep[4*i +: 4]) && (word[31:30] == 2'b01) && (n < TAG_LIMIT);
         if (n < CC_N) begin
            idx            = CH_ADDR_W'(n);
            lane_chan_s[i] = n + 6'd1;
         end else begin
            idx            = CH_ADDR_W'(n - CC_N);
            lane_chan_s[i] = CC_N - 6'd1 - n;
         end
         // Only look up configuration for real tags so idx stays in range.
         if (is_tag) begin
            en            = enable_r[idx];
            lane_off_s[i] = offset_r[idx];
         end else begin
            en            = 1'b0;
            lane_off_s[i] = 32'd0;
         end
         lane_keep_s[i] = accept_s && is_tag && en;
         lane_drop_s[i] = accept_s && is_tag && !en;
         if (lane_drop_s[i]) begin
            drop_inc_s = drop_inc_s + 32'd1;
         end else begin
            drop_inc_s = drop_inc_s;
         end
         lane_sub_s[i]  = word[23:12];
         // {epoch, wrap, counter} is 76 bits; only the low 64 bits survive
         // the truncated product, so the top 12 epoch bits are not needed.
         lane_prod_s[i] = {rollover_next_s[19:0], s_axis_tuser, word[11:0]} * SCALE;
      end
      drop_sum_s = {1'b0, drop_cnt_r} + {1'b0, drop_inc_s};
   end

   // Configuration table; out-of-range addresses are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNEL_COUNT; i++) begin
            offset_r[i] <= 32'd0;
         end
         enable_r <= '1;
      end else if (cfg_we && ({1'b0, cfg_addr} < (CH_ADDR_W + 1)'(CHANNEL_COUNT))) begin
         offset_r[cfg_addr] <= cfg_offset;
         enable_r[cfg_addr] <= cfg_enable;
      end
   end

   // Rollover epoch and saturating dropped-tag counter, updated per accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         rollover_r   <= 32'd0;
         prev_tuser_r <= 32'd0;
         prev_valid_r <= 1'b0;
         drop_cnt_r   <= 32'd0;
      end else if (accept_s) begin
         rollover_r   <= rollover_next_s;
         prev_tuser_r <= s_axis_tuser;
         prev_valid_r <= 1'b1;
         drop_cnt_r   <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
      end
   end

   // Four-stage datapath: multiply, +subtime, +offset, output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_keep_r      <= '0;
         s1_chan_r      <= '0;
         s1_prod_r      <= '0;
         s1_sub_r       <= '0;
         s1_off_r       <= '0;
         s2_keep_r      <= '0;
         s2_chan_r      <= '0;
         s2_sum_r       <= '0;
         s2_off_r       <= '0;
         s3_keep_r      <= '0;
         s3_chan_r      <= '0;
         s3_time_r      <= '0;
         m_axis_tvalid  <= 1'b0;
         m_axis_tkeep   <= '0;
         m_axis_channel <= '0;
         m_axis_tagtime <= '0;
      end else if (advance_s) begin
         s1_keep_r      <= lane_keep_s;
         s1_chan_r      <= lane_chan_s;
         s1_prod_r      <= lane_prod_s;
         s1_sub_r       <= lane_sub_s;
         s1_off_r       <= lane_off_s;
         s2_keep_r      <= s1_keep_r;
         s2_chan_r      <= s1_chan_r;
         s2_off_r       <= s1_off_r;
         s3_keep_r      <= s2_keep_r;
         s3_chan_r      <= s2_chan_r;
         for (int i = 0; i < NW; i++) begin
            s2_sum_r[i]  <= s1_prod_r[i] + {52'd0, s1_sub_r[i]};
            s3_time_r[i] <= s2_sum_r[i] + {{32{s2_off_r[i][31]}}, s2_off_r[i]};
         end
         m_axis_tvalid  <= |s3_keep_r;
         m_axis_tkeep   <= s3_keep_r;
         m_axis_channel <= s3_chan_r;
         m_axis_tagtime <= s3_time_r;
      end
   end

endmodule

// File: tb/tb_si_tag_decoder.sv
// Testbench for si_tag_decoder: vector table plus hand sequences, with a
// scoreboard queue of expected output beats checked by a monitor process.
module tb_si_tag_decoder;

   localparam int NW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [127:0]      s_axis_tdata;
   logic              s_axis_tlast;
   logic [15:0]       s_axis_tkeep;
   logic [31:0]       s_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [3:0][63:0]  m_axis_tagtime;
   logic [3:0][5:0]   m_axis_channel;
   logic [3:0]        m_axis_tkeep;
   logic              cfg_we;
   logic [4:0]        cfg_addr;
   logic [31:0]       cfg_offset;
   logic              cfg_enable;
   logic [31:0]       dropped_count;
   logic [31:0]       rollover_count;

   always #5 clk = ~clk;

   si_tag_decoder dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tagtime(m_axis_tagtime), .m_axis_channel(m_axis_channel),
      .m_axis_tkeep(m_axis_tkeep),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_offset(cfg_offset),
      .cfg_enable(cfg_enable),
      .dropped_count(dropped_count), .rollover_count(rollover_count)
   );

   typedef struct {
      logic [3:0]       keep;
      logic [3:0][5:0]  ch;
      logic [3:0][63:0] tt;
   } exp_t;

   typedef struct {
      logic [127:0]     data;
      logic [15:0]      keep;
      logic [31:0]      tuser;
      logic [3:0]       ekeep;
      logic [3:0][5:0]  ech;
      logic [3:0][63:0] ett;
   } vec_t;

   exp_t sb[$];
   vec_t vt[7];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mkw(input logic [1:0] t, input logic [5:0] n,
                                       input logic [11:0] sub, input logic [11:0] cnt);
      return {t, n, sub, cnt};
   endfunction

   function automatic logic [5:0] sch(input int v);
      return 6'(v);
   endfunction

   task automatic push1(input int lane, input logic [5:0] ch, input logic [63:0] tt);
      exp_t e;
      e.keep = 4'd0;
      e.ch   = '0;
      e.tt   = '0;
      e.keep[lane] = 1'b1;
      e.ch[lane]   = ch;
      e.tt[lane]   = tt;
      sb.push_back(e);
   endtask

   task automatic send(input logic [127:0] d, input logic [15:0] k, input logic [31:0] u);
      int n;
      n = 0;
      @(negedge clk);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      #1;
      while (!s_axis_tready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got tready 0 for %0d cycles expected 1", n);
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic cfgw(input logic [4:0] a, input logic [31:0] off, input logic en);
      @(negedge clk);
      cfg_we     = 1'b1;
      cfg_addr   = a;
      cfg_offset = off;
      cfg_enable = en;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      s_axis_tvalid = 1'b0;
      cfg_we        = 1'b0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      #2;
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   // Monitor: a beat transfers at the next rising edge when valid and ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got keep %b expected no output", m_axis_tkeep);
            end else begin
               e = sb.pop_front();
               chk("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
               for (int i = 0; i < NW; i++) begin
                  if (e.keep[i]) begin
                     chk($sformatf("out_ch_lane%0d", i), 64'(m_axis_channel[i]), 64'(e.ch[i]));
                     chk($sformatf("out_time_lane%0d", i), m_axis_tagtime[i], e.tt[i]);
                  end
               end
            end
         end
      end
   end

   initial begin
      exp_t e;
      int   lat;
      logic [63:0] base_pre;
      logic [63:0] base_post;

      rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
      s_axis_tkeep = '0; s_axis_tuser = '0; m_axis_tready = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_offset = '0; cfg_enable = 1'b0;

      // vector table: all offsets 0, all channels enabled
      for (int i = 0; i < 7; i++) begin
         vt[i].ekeep = 4'd0; vt[i].ech = '0; vt[i].ett = '0;
      end
      vt[0].data = {96'd0, mkw(2'd1, 6'd1, 12'd1, 12'd5)}; vt[0].keep = 16'h000F; vt[0].tuser = 32'd0;
      vt[0].ekeep = 4'b0001; vt[0].ech[0] = 6'd2; vt[0].ett[0] = 64'd20001;
      vt[1].data = {mkw(2'd1, 6'd20, 12'd2, 12'd3), mkw(2'd0, 6'd3, 12'd0, 12'd0),
                    mkw(2'd1, 6'd40, 12'd0, 12'd0), mkw(2'd1, 6'd39, 12'd0, 12'd7)};
      vt[1].keep = 16'hFFFF; vt[1].tuser = 32'd0; vt[1].ekeep = 4'b1001;
      vt[1].ech[3] = sch(-1); vt[1].ett[3] = 64'd12002;
      vt[1].ech[0] = sch(-20); vt[1].ett[0] = 64'd28000;
      vt[2].data = {mkw(2'd1, 6'd21, 12'd100, 12'd0), mkw(2'd1, 6'd10, 12'd0, 12'd0),
                    mkw(2'd1, 6'd19, 12'd4095, 12'd4095), mkw(2'd1, 6'd0, 12'd0, 12'd1)};
      vt[2].keep = 16'hF0F7; vt[2].tuser = 32'd0; vt[2].ekeep = 4'b1010;
      vt[2].ech[1] = 6'd20; vt[2].ett[1] = 64'd16384095;
      vt[2].ech[3] = sch(-2); vt[2].ett[3] = 64'd100;
      vt[3].data = {96'd0, mkw(2'd1, 6'd1, 12'd1, 12'd5)}; vt[3].keep = 16'h0000; vt[3].tuser = 32'd0;
      vt[4].data = {32'd0, mkw(2'd1, 6'd7, 12'd3, 12'd2), 64'd0}; vt[4].keep = 16'h0F00;
      vt[4].tuser = 32'd1; vt[4].ekeep = 4'b0100; vt[4].ech[2] = 6'd8; vt[4].ett[2] = 64'd16392003;
      vt[5].data = {mkw(2'd1, 6'd3, 12'd3, 12'd3), mkw(2'd1, 6'd2, 12'd2, 12'd2),
                    mkw(2'd1, 6'd1, 12'd1, 12'd1), mkw(2'd1, 6'd0, 12'd0, 12'd0)};
      vt[5].keep = 16'hFFFF; vt[5].tuser = 32'd2; vt[5].ekeep = 4'b1111;
      vt[5].ech[0] = 6'd1; vt[5].ett[0] = 64'd32768000;
      vt[5].ech[1] = 6'd2; vt[5].ett[1] = 64'd32772001;
      vt[5].ech[2] = 6'd3; vt[5].ett[2] = 64'd32776002;
      vt[5].ech[3] = 6'd4; vt[5].ett[3] = 64'd32780003;
      vt[6].data = {mkw(2'd3, 6'd1, 12'd0, 12'd0), mkw(2'd2, 6'd1, 12'd0, 12'd0),
                    mkw(2'd1, 6'd63, 12'd0, 12'd0), mkw(2'd0, 6'd0, 12'd0, 12'd0)};
      vt[6].keep = 16'hFFFF; vt[6].tuser = 32'd2;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      chk("rst_tagtime0", m_axis_tagtime[0], 64'd0);
      chk("rst_channel", 64'(m_axis_channel), 64'd0);
      chk("rst_rollover", 64'(rollover_count), 64'd0);
      chk("rst_dropped", 64'(dropped_count), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // latency: accepted at cycle t, visible at t+4 (third edge after acceptance)
      push1(0, 6'd2, 64'd20001);
      send(vt[0].data, vt[0].keep, vt[0].tuser);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (m_axis_tvalid) begin
            lat = k;
            break;
         end
      end
      chk("latency_edges", 64'(lat), 64'd3);
      drain("drain_latency");

      // vector table, back to back
      for (int i = 0; i < 7; i++) begin
         if (vt[i].ekeep != 4'd0) begin
            e.keep = vt[i].ekeep; e.ch = vt[i].ech; e.tt = vt[i].ett;
            sb.push_back(e);
         end
         send(vt[i].data, vt[i].keep, vt[i].tuser);
      end
      drain("drain_table");
      chk("table_rollover", 64'(rollover_count), 64'd0);

      // offsets: negative wrap, same-cycle write uses old value
      do_reset();
      cfgw(5'd2, -32'sd30000, 1'b1);
      push1(0, 6'd3, 64'hFFFF_FFFF_FFFF_9A70);
      send({96'd0, mkw(2'd1, 6'd2, 12'd0, 12'd1)}, 16'h000F, 32'd0);
      chk("first_beat_no_rollover", 64'(rollover_count), 64'd0);
      push1(0, 6'd3, 64'hFFFF_FFFF_FFFF_9A70);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 5'd2; cfg_offset = 32'd500; cfg_enable = 1'b1;
      s_axis_tdata = {96'd0, mkw(2'd1, 6'd2, 12'd0, 12'd1)}; s_axis_tkeep = 16'h000F;
      s_axis_tuser = 32'd0; s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0; s_axis_tvalid = 1'b0;
      push1(0, sch(-3), 64'd4500);
      send({96'd0, mkw(2'd1, 6'd22, 12'd0, 12'd1)}, 16'h000F, 32'd0);
      cfgw(5'd20, 32'd12345, 1'b0);
      push1(0, 6'd1, 64'd4000);
      send({96'd0, mkw(2'd1, 6'd0, 12'd0, 12'd1)}, 16'h000F, 32'd0);
      drain("drain_offset");

      // enable mask and saturating drop counter
      cfgw(5'd5, 32'd0, 1'b0);
      push1(3, 6'd7, 64'd4000);
      send({mkw(2'd1, 6'd6, 12'd0, 12'd1), mkw(2'd1, 6'd5, 12'd0, 12'd1),
            mkw(2'd1, 6'd25, 12'd0, 12'd1), mkw(2'd1, 6'd5, 12'd0, 12'd1)}, 16'hFFFF, 32'd0);
      chk("dropped_3", 64'(dropped_count), 64'd3);
      @(negedge clk);
      force dut.drop_cnt_r = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.drop_cnt_r;
      #1;
      chk("dropped_forced", 64'(dropped_count), 64'hFFFF_FFFE);
      send({mkw(2'd0, 6'd5, 12'd0, 12'd1), mkw(2'd1, 6'd5, 12'd0, 12'd1),
            mkw(2'd1, 6'd25, 12'd0, 12'd1), mkw(2'd1, 6'd5, 12'd0, 12'd1)}, 16'hFFFF, 32'd0);
      chk("dropped_saturate", 64'(dropped_count), 64'hFFFF_FFFF);
      send({96'd0, mkw(2'd1, 6'd25, 12'd0, 12'd1)}, 16'h000F, 32'd0);
      chk("dropped_hold_sat", 64'(dropped_count), 64'hFFFF_FFFF);
      drain("drain_enable");

      // rollover epoch (reset also restores offsets and enables)
      do_reset();
      chk("rst_dropped_again", 64'(dropped_count), 64'd0);
      base_pre  = 64'd17592186040322 * 64'd4000;
      base_post = 64'd17592186044416 * 64'd4000;
      e.keep = 4'b0011; e.ch = '0; e.tt = '0;
      e.ch[0] = 6'd3; e.tt[0] = base_pre + 64'd1;
      e.ch[1] = 6'd6; e.tt[1] = base_pre;
      sb.push_back(e);
      send({64'd0, mkw(2'd1, 6'd5, 12'd0, 12'd2), mkw(2'd1, 6'd2, 12'd1, 12'd2)}, 16'h00FF, 32'hFFFF_FFFF);
      chk("rollover_first", 64'(rollover_count), 64'd0);
      push1(0, 6'd2, base_post + 64'd12004);
      send({96'd0, mkw(2'd1, 6'd1, 12'd4, 12'd3)}, 16'h000F, 32'd0);
      chk("rollover_wrap", 64'(rollover_count), 64'd1);
      push1(0, 6'd2, base_post + 64'd12004);
      send({96'd0, mkw(2'd1, 6'd1, 12'd4, 12'd3)}, 16'h000F, 32'd0);
      chk("rollover_equal", 64'(rollover_count), 64'd1);
      drain("drain_rollover");

      // stall: output held, input refused, nothing lost
      do_reset();
      @(negedge clk);
      m_axis_tready = 1'b0;
      push1(0, 6'd4, 64'd4000);
      send({96'd0, mkw(2'd1, 6'd3, 12'd0, 12'd1)}, 16'h000F, 32'd0);
      push1(0, 6'd5, 64'd8000);
      send({96'd0, mkw(2'd1, 6'd4, 12'd0, 12'd2)}, 16'h000F, 32'd0);
      push1(0, 6'd7, 64'd12000);
      send({96'd0, mkw(2'd1, 6'd6, 12'd0, 12'd3)}, 16'h000F, 32'd0);
      push1(0, 6'd8, 64'd16000);
      send({96'd0, mkw(2'd1, 6'd7, 12'd0, 12'd4)}, 16'h000F, 32'd0);
      push1(0, 6'd9, 64'd20000);
      @(negedge clk);
      s_axis_tdata = {96'd0, mkw(2'd1, 6'd8, 12'd0, 12'd5)}; s_axis_tkeep = 16'h000F;
      s_axis_tuser = 32'd0; s_axis_tvalid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("stall_s_tready", 64'(s_axis_tready), 64'd0);
         chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
         chk("stall_tkeep", 64'(m_axis_tkeep), 64'd1);
         chk("stall_time", m_axis_tagtime[0], 64'd4000);
         chk("stall_ch", 64'(m_axis_channel[0]), 64'd4);
         @(negedge clk);
      end
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      drain("drain_stall");
      chk("stall_rollover", 64'(rollover_count), 64'd0);

      // reset while stalled discards the pipeline
      @(negedge clk);
      m_axis_tready = 1'b0;
      send({96'd0, mkw(2'd1, 6'd3, 12'd0, 12'd1)}, 16'h000F, 32'd0);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         #1;
         if (m_axis_tvalid) begin
            lat = k;
            break;
         end
      end
      chk("stall2_reached", 64'(lat != 0), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("midrst_tkeep", 64'(m_axis_tkeep), 64'd0);
      chk("midrst_time", m_axis_tagtime[0], 64'd0);
      chk("midrst_ch", 64'(m_axis_channel), 64'd0);
      chk("midrst_s_tready", 64'(s_axis_tready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      m_axis_tready = 1'b1;
      sb.delete();
      repeat (6) @(negedge clk);
      #1;
      chk("midrst_flushed", 64'(m_axis_tvalid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
